// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: FIFO of outstanding predictions, retired in order to train the predictor.
// Optional BR_RESOLVE_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     alloc_v_i,
    input  logic                     alloc_pred_i,
    input  logic [IDX_W-1:0]         alloc_idx_i,
    output logic                     alloc_ready_o,
    input  logic                     res_v_i,
    input  logic                     res_taken_i,
    output logic                     update_o,
    output logic                     brTaken_o,
    output logic [IDX_W-1:0]         updIdx_o,
    output logic                     mispredict_o,
    output logic [$clog2(DEPTH):0]   count_o,
`ifdef BR_RESOLVE_STATS_EN
    output logic [15:0]              resolved_cnt_o,
    output logic [15:0]              mispred_cnt_o,
`endif
    output logic                     underflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic             pred_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem  [DEPTH];

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             update_q, update_d;
    logic             taken_q, taken_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             mispred_q, mispred_d;
    logic             underflow_q, underflow_d;

    logic             empty;
    logic             do_alloc;
    logic             do_pop;
    logic             mis;
    logic             wr_en;

    assign empty         = (count_q == '0);
    assign alloc_ready_o = (count_q < CW'(DEPTH));
    assign do_alloc      = alloc_v_i & alloc_ready_o;
    assign do_pop        = res_v_i & ~empty;
    assign mis           = do_pop & (pred_mem[head_q] != res_taken_i);
    // A mispredicting pop kills the same-cycle allocation along with the rest of the queue.
    assign wr_en         = do_alloc & ~mis;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        update_d    = do_pop;
        mispred_d   = mis;
        taken_d     = taken_q;
        upd_idx_d   = upd_idx_q;
        underflow_d = underflow_q | (res_v_i & empty);

        if (do_pop) begin
            taken_d   = res_taken_i;
            upd_idx_d = idx_mem[head_q];
        end

        if (mis) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (wr_en) begin
                tail_d = tail_q + PW'(1);
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            update_q    <= 1'b0;
            taken_q     <= 1'b0;
            upd_idx_q   <= '0;
            mispred_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            update_q    <= update_d;
            taken_q     <= taken_d;
            upd_idx_q   <= upd_idx_d;
            mispred_q   <= mispred_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale entries are never read because count gates every pop.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && wr_en) begin
            pred_mem[tail_q] <= alloc_pred_i;
            idx_mem[tail_q]  <= alloc_idx_i;
        end
    end

    assign update_o     = update_q;
    assign brTaken_o    = taken_q;
    assign updIdx_o     = upd_idx_q;
    assign mispredict_o = mispred_q;
    assign count_o      = count_q;
    assign underflow_o  = underflow_q;

`ifdef BR_RESOLVE_STATS_EN
    logic [15:0] resolved_cnt_q;
    logic [15:0] mispred_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            if (update_q && (resolved_cnt_q != 16'hFFFF)) begin
                resolved_cnt_q <= resolved_cnt_q + 16'd1;
            end
            if (mispred_q && (mispred_cnt_q != 16'hFFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
        end
    end

    assign resolved_cnt_o = resolved_cnt_q;
    assign mispred_cnt_o  = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue at DEPTH=8, IDX_W=6: a vector table plus
// hand-written sequences for full, flush, wrap and (with BR_RESOLVE_STATS_EN) stats.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             alloc_v;
    logic             alloc_pred;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_ready;
    logic             res_v;
    logic             res_taken;
    logic             update;
    logic             br_taken;
    logic [IDX_W-1:0] upd_idx;
    logic             mispredict;
    logic [3:0]       count;
    logic             underflow;
`ifdef BR_RESOLVE_STATS_EN
    logic [15:0]      resolved_cnt;
    logic [15:0]      mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .alloc_v_i     (alloc_v),
        .alloc_pred_i  (alloc_pred),
        .alloc_idx_i   (alloc_idx),
        .alloc_ready_o (alloc_ready),
        .res_v_i       (res_v),
        .res_taken_i   (res_taken),
        .update_o      (update),
        .brTaken_o     (br_taken),
        .updIdx_o      (upd_idx),
        .mispredict_o  (mispredict),
        .count_o       (count),
`ifdef BR_RESOLVE_STATS_EN
        .resolved_cnt_o(resolved_cnt),
        .mispred_cnt_o (mispred_cnt),
`endif
        .underflow_o   (underflow)
    );

    typedef struct {
        int rst_n; int av; int ap; int ai; int rv; int rt;
        int e_rdy; int e_upd; int e_tk; int e_idx; int e_mis; int e_cnt; int e_uf;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int rst_n, input int av, input int ap, input int ai,
                         input int rv, input int rt);
        reset_n    = rst_n[0];
        alloc_v    = av[0];
        alloc_pred = ap[0];
        alloc_idx  = IDX_W'(ai);
        res_v      = rv[0];
        res_taken  = rt[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue model used by the hand-written sequences.
    int exp_idx_q [$];
    int exp_pred_q [$];

    task automatic push(input int pred, input int idx);
        exp_pred_q.push_back(pred);
        exp_idx_q.push_back(idx);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        //              rst av ap ai rv rt | rdy upd tk idx mis cnt uf
        vt[0]  = '{0, 0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0};
        vt[1]  = '{1, 0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0};
        vt[2]  = '{1, 1, 1, 5,  0, 0,  1, 0, 0, 0,  0, 1, 0};
        vt[3]  = '{1, 0, 0, 0,  1, 1,  1, 1, 1, 5,  0, 0, 0};
        vt[4]  = '{1, 0, 0, 0,  0, 0,  1, 0, 1, 5,  0, 0, 0};
        vt[5]  = '{1, 1, 0, 9,  0, 0,  1, 0, 1, 5,  0, 1, 0};
        vt[6]  = '{1, 1, 1, 12, 1, 1,  1, 1, 1, 9,  1, 0, 0};
        vt[7]  = '{1, 0, 0, 0,  0, 0,  1, 0, 1, 9,  0, 0, 0};
        vt[8]  = '{1, 1, 0, 3,  1, 0,  1, 0, 1, 9,  0, 1, 1};
        vt[9]  = '{1, 0, 0, 0,  1, 0,  1, 1, 0, 3,  0, 0, 1};
        vt[10] = '{1, 0, 0, 0,  1, 1,  1, 0, 0, 3,  0, 0, 1};
        vt[11] = '{0, 1, 1, 7,  1, 1,  1, 0, 0, 0,  0, 0, 0};
        vt[12] = '{1, 0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst_n, vt[i].av, vt[i].ap, vt[i].ai, vt[i].rv, vt[i].rt);
            tick();
            chk($sformatf("v%0d ready", i), int'(alloc_ready), vt[i].e_rdy);
            chk($sformatf("v%0d update", i), int'(update), vt[i].e_upd);
            chk($sformatf("v%0d taken", i), int'(br_taken), vt[i].e_tk);
            chk($sformatf("v%0d idx", i), int'(upd_idx), vt[i].e_idx);
            chk($sformatf("v%0d mispredict", i), int'(mispredict), vt[i].e_mis);
            chk($sformatf("v%0d count", i), int'(count), vt[i].e_cnt);
            chk($sformatf("v%0d underflow", i), int'(underflow), vt[i].e_uf);
        end

        // Fill to DEPTH, then an ignored extra alloc, then drain in order.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, i % 2, 10 + i, 0, 0);
            push(i % 2, 10 + i);
            tick();
            chk($sformatf("fill%0d count", i), int'(count), i + 1);
            chk($sformatf("fill%0d ready", i), int'(alloc_ready), (i == 7) ? 0 : 1);
        end
        drive(1, 1, 1, 63, 0, 0);
        tick();
        chk("full extra count", int'(count), 8);
        chk("full extra ready", int'(alloc_ready), 0);
        for (int i = 0; i < 8; i++) begin
            int p, x;
            p = exp_pred_q.pop_front();
            x = exp_idx_q.pop_front();
            drive(1, 0, 0, 0, 1, p);
            tick();
            chk($sformatf("drain%0d update", i), int'(update), 1);
            chk($sformatf("drain%0d idx", i), int'(upd_idx), x);
            chk($sformatf("drain%0d mispredict", i), int'(mispredict), 0);
            chk($sformatf("drain%0d count", i), int'(count), 7 - i);
        end
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("drain idle update", int'(update), 0);
        chk("drain underflow", int'(underflow), 0);

        // Mispredict on the oldest of three flushes everything, including a same-cycle alloc.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 20 + i, 0, 0);
            tick();
        end
        chk("flush pre count", int'(count), 3);
        drive(1, 1, 0, 30, 1, 0);
        tick();
        chk("flush update", int'(update), 1);
        chk("flush mispredict", int'(mispredict), 1);
        chk("flush idx", int'(upd_idx), 20);
        chk("flush taken", int'(br_taken), 0);
        chk("flush count", int'(count), 0);
        drive(1, 1, 0, 40, 0, 0);
        tick();
        chk("post flush mispredict", int'(mispredict), 0);
        chk("post flush count", int'(count), 1);
        drive(1, 0, 0, 0, 1, 0);
        tick();
        chk("post flush idx", int'(upd_idx), 40);
        chk("post flush pop mispredict", int'(mispredict), 0);
        chk("post flush pop count", int'(count), 0);

        // Twelve alloc/resolve pairs overlapping by one entry: pointers wrap.
        drive(1, 1, 0, 32, 0, 0);
        push(0, 32);
        tick();
        chk("wrap prime count", int'(count), 1);
        for (int i = 1; i <= 12; i++) begin
            int p, x;
            p = exp_pred_q.pop_front();
            x = exp_idx_q.pop_front();
            if (i < 12) begin
                drive(1, 1, i % 2, 32 + i, 1, p);
                push(i % 2, 32 + i);
            end else begin
                drive(1, 0, 0, 0, 1, p);
            end
            tick();
            chk($sformatf("wrap%0d update", i), int'(update), 1);
            chk($sformatf("wrap%0d idx", i), int'(upd_idx), x);
            chk($sformatf("wrap%0d mispredict", i), int'(mispredict), 0);
            chk($sformatf("wrap%0d count", i), int'(count), (i < 12) ? 1 : 0);
        end

        // Underflow is sticky until reset.
        drive(1, 0, 0, 0, 1, 1);
        tick();
        chk("uf update", int'(update), 0);
        chk("uf set", int'(underflow), 1);
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("uf sticky", int'(underflow), 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("uf reset", int'(underflow), 0);

`ifdef BR_RESOLVE_STATS_EN
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("stats reset resolved", int'(resolved_cnt), 0);
        chk("stats reset mispred", int'(mispred_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1 + i, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("stats resolved", int'(resolved_cnt), 3);
        chk("stats mispred", int'(mispred_cnt), 1);
        drive(1, 1, 1, 9, 0, 0);
        tick();
        drive(0, 1, 0, 4, 1, 0);
        tick();
        chk("stats midreset resolved", int'(resolved_cnt), 0);
        chk("stats midreset mispred", int'(mispred_cnt), 0);
        chk("stats midreset count", int'(count), 0);
        chk("stats midreset update", int'(update), 0);
        chk("stats midreset idx", int'(upd_idx), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of outstanding predicted branches (power of two, 2..32).
REQ-002 SHALL have parameter IDX_W, default 6, meaning the predictor-table index width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port alloc_v_i, input, 1 bit: fetch issues a predicted branch this cycle.
REQ-006 SHALL have port alloc_pred_i, input, 1 bit: prediction given at fetch (1 = taken).
REQ-007 SHALL have port alloc_idx_i, input, IDX_W bits: predictor-table entry used for the prediction.
REQ-008 SHALL have port alloc_ready_o, output, 1 bit: queue can accept an allocation this cycle.
REQ-009 SHALL have port res_v_i, input, 1 bit: the oldest outstanding branch resolves this cycle (in program order).
REQ-010 SHALL have port res_taken_i, input, 1 bit: actual outcome of the resolving branch.
REQ-011 SHALL have port update_o, output, 1 bit: one-cycle pulse that writes the predictor counter.
REQ-012 SHALL have port brTaken_o, output, 1 bit: actual outcome sent with update_o.
REQ-013 SHALL have port updIdx_o, output, IDX_W bits: predictor entry to update.
REQ-014 SHALL have port mispredict_o, output, 1 bit: one-cycle pulse when the actual outcome differs from the stored prediction.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-016 SHALL have port underflow_o, output, 1 bit: sticky error flag for a resolution arriving while the queue is empty.

Function
REQ-017 SHALL store {alloc_pred_i, alloc_idx_i} in a circular FIFO at the tail when alloc_v_i & alloc_ready_o.
REQ-018 SHALL drive alloc_ready_o = (count_o < DEPTH) combinationally from registered occupancy.
REQ-019 SHALL ignore alloc_v_i while alloc_ready_o = 0: no write, and no change to any pointer or count.
REQ-020 SHALL pop the head entry on res_v_i when count_o > 0.
REQ-021 SHALL, one cycle after a pop, register update_o = 1, brTaken_o = res_taken_i, updIdx_o = the head idx, and mispredict_o = (head pred != res_taken_i).
REQ-022 SHALL hold update_o and mispredict_o at 0 in every cycle with no pop in the previous cycle; brTaken_o and updIdx_o hold their last values.
REQ-023 SHALL let head and tail pointers wrap modulo DEPTH, with no bubble at the wrap.
REQ-024 SHALL, on a pop with a misprediction, flush all remaining entries: head = tail, count = 0 at the next edge.
REQ-025 SHALL discard a same-cycle allocation when that cycle's pop mispredicts.
REQ-026 SHALL, on a simultaneous alloc and pop without a misprediction, leave count unchanged and advance both pointers.
REQ-027 SHALL, on a simultaneous alloc and pop with an empty queue, accept the alloc and ignore the resolve: no bypass, no update_o, and underflow_o is set.
REQ-028 SHALL, on res_v_i with count 0, produce no update and set underflow_o, which stays 1 until reset.

Reset
REQ-029 SHALL, while reset_n_i = 0 at a clock edge, set head = tail = 0, count_o = 0, update_o = 0, mispredict_o = 0, brTaken_o = 0, updIdx_o = 0, underflow_o = 0.
REQ-030 SHALL discard any in-flight alloc or resolve coincident with reset, leaving FIFO storage contents don't-care.
REQ-031 SHALL drive alloc_ready_o = 1 in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL, when BR_RESOLVE_STATS_EN is defined, add outputs resolved_cnt_o[15:0] and mispred_cnt_o[15:0], both reset to 0.
REQ-033 SHALL increment these counters on update_o and mispredict_o respectively, saturating at 16'hFFFF.
REQ-034 SHALL, without BR_RESOLVE_STATS_EN, have neither the counter ports nor the counter logic present.

Verification
REQ-035 SHALL cover: alloc (pred=1, idx=5), then resolve taken=1 -> next cycle update_o=1, brTaken_o=1, updIdx_o=5, mispredict_o=0, count_o back to 0.
REQ-036 SHALL cover: alloc 8 entries, then a 9th alloc -> alloc_ready_o=0 after the 8th, 9th ignored, count_o=8; resolving all 8 returns idx values in allocation order.
REQ-037 SHALL cover: 3 entries queued, oldest pred=1, resolve taken=0 with a same-cycle alloc -> mispredict_o=1, updIdx_o=oldest idx, count_o=0, same-cycle alloc dropped.
REQ-038 SHALL cover: 12 alloc/resolve pairs with correct predictions at DEPTH=8 -> pointers wrap, every updIdx_o matches, mispredict_o never asserted.
REQ-039 SHALL cover: res_v_i on an empty queue -> update_o stays 0, underflow_o=1 and sticky until reset_n_i=0.
REQ-040 SHALL cover: with BR_RESOLVE_STATS_EN, 3 resolves with 1 mispredict -> resolved_cnt_o=3, mispred_cnt_o=1; then reset mid-stream -> all outputs 0.
